// File: rtl/edge_detector_if.sv
// Level-in / pulse-out bundle for edge_detector.
// The master drives the watched levels; the slave returns the per-bit pulses.
interface edge_detector_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] any_edge;

  modport master (output in, input rise, fall, any_edge);
  modport slave  (input in, output rise, fall, any_edge);
endinterface

// File: rtl/edge_detector.sv
// Per-bit rise/fall/any-edge pulse generator with same-cycle combinational outputs.
// Optional input synchronizer chain enabled by macro EDGE_DET_SYNC_EN.
module edge_detector #(
  parameter int WIDTH       = 1,
  parameter bit RESET_VAL   = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            reset,
  edge_detector_if.slave bus
);

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] prev_d;

  if (SYNC_STAGES < 2) begin : g_sync_stages_invalid
    $error("edge_detector: SYNC_STAGES must be at least 2");
  end

`ifdef EDGE_DET_SYNC_EN
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];

  always_comb begin
    sync_d[0] = bus.in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Chain resets to RESET_VAL so the first post-reset compare sees a clean history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= {WIDTH{RESET_VAL}};
      end
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];
`else
  assign s = bus.in;
`endif

  assign prev_d = s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= {WIDTH{RESET_VAL}};
    end else begin
      prev_q <= prev_d;
    end
  end

  // Pulses are gated by reset so they vanish asynchronously, not at the next edge.
  always_comb begin
    bus.rise     = '0;
    bus.fall     = '0;
    bus.any_edge = '0;
    if (!reset) begin
      bus.rise     = s & ~prev_q;
      bus.fall     = ~s & prev_q;
      bus.any_edge = s ^ prev_q;
    end
  end

endmodule

// File: tb/tb_edge_detector.sv
// Bench for edge_detector: three instances (1-bit RESET_VAL=0, 1-bit RESET_VAL=1, 4-bit)
// checked against a sample-history model with directed and random stimulus.
module tb_edge_detector;

`ifdef EDGE_DET_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [3:0] q0[$];
  logic [3:0] q1[$];
  logic [3:0] q2[$];

  always #5 clk = ~clk;

  edge_detector_if #(.WIDTH(1)) b0 ();
  edge_detector_if #(.WIDTH(1)) b1 ();
  edge_detector_if #(.WIDTH(4)) b2 ();

  edge_detector #(.WIDTH(1), .RESET_VAL(1'b0), .SYNC_STAGES(2)) d0 (.clk(clk), .reset(reset), .bus(b0));
  edge_detector #(.WIDTH(1), .RESET_VAL(1'b1), .SYNC_STAGES(2)) d1 (.clk(clk), .reset(reset), .bus(b1));
  edge_detector #(.WIDTH(4), .RESET_VAL(1'b0), .SYNC_STAGES(2)) d2 (.clk(clk), .reset(reset), .bus(b2));

  // Watched value: the live input, or the input sampled LAT edges ago.
  function automatic logic [3:0] hist_s(input logic [3:0] q[$], input logic [3:0] cur);
    if (LAT == 0) return cur;
    return q[q.size()-LAT];
  endfunction

  function automatic logic [3:0] hist_p(input logic [3:0] q[$]);
    return q[q.size()-1-LAT];
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input string tag, input logic [3:0] q[$], input logic [3:0] cur,
                           input logic [3:0] mask, input logic [3:0] r, input logic [3:0] f,
                           input logic [3:0] a);
    logic [3:0] s, p, er, ef, ea;
    s  = hist_s(q, cur) & mask;
    p  = hist_p(q) & mask;
    er = reset ? 4'h0 : (s & ~p);
    ef = reset ? 4'h0 : (~s & p & mask);
    ea = reset ? 4'h0 : (s ^ p);
    chk({tag, ".rise"}, r, er);
    chk({tag, ".fall"}, f, ef);
    chk({tag, ".any"}, a, ea);
    chk({tag, ".both"}, r & f, 4'h0);
  endtask

  task automatic check_all(input string tag);
    check_dut({tag, "/d0"}, q0, {3'b0, b0.in}, 4'h1, {3'b0, b0.rise}, {3'b0, b0.fall}, {3'b0, b0.any_edge});
    check_dut({tag, "/d1"}, q1, {3'b0, b1.in}, 4'h1, {3'b0, b1.rise}, {3'b0, b1.fall}, {3'b0, b1.any_edge});
    check_dut({tag, "/d2"}, q2, b2.in, 4'hF, b2.rise, b2.fall, b2.any_edge);
  endtask

  task automatic fill_hist();
    q0 = {}; q1 = {}; q2 = {};
    repeat (LAT + 1) begin
      q0.push_back(4'h0);
      q1.push_back(4'h1);
      q2.push_back(4'h0);
    end
  endtask

  task automatic step(input logic a, input logic b, input logic [3:0] c, input string tag);
    @(posedge clk);
    if (!reset) begin
      q0.push_back({3'b0, b0.in});
      q1.push_back({3'b0, b1.in});
      q2.push_back(b2.in);
      if (q0.size() > LAT + 1) void'(q0.pop_front());
      if (q1.size() > LAT + 1) void'(q1.pop_front());
      if (q2.size() > LAT + 1) void'(q2.pop_front());
    end
    #1;
    b0.in = a;
    b1.in = b;
    b2.in = c;
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic reset_assert(input string tag);
    #1 reset = 1'b1;
    fill_hist();
    #1 check_all(tag);
  endtask

  task automatic hold_reset(input string tag);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1 check_all(tag);
  endtask

  initial begin
    reset = 1'b1;
    b0.in = 1'b0;
    b1.in = 1'b1;
    b2.in = 4'h0;
    fill_hist();
    #1 check_all("reset");
    hold_reset("release0");

    repeat (3) step(1'b0, 1'b1, 4'h0, "low");
    step(1'b1, 1'b1, 4'h0, "rise1");
`ifndef EDGE_DET_SYNC_EN
    chk("rise_first", {3'b0, b0.rise}, 4'h1);
`endif
    repeat (4) step(1'b1, 1'b1, 4'h0, "high");
`ifndef EDGE_DET_SYNC_EN
    chk("rise_held", {3'b0, b0.rise}, 4'h0);
`endif
    step(1'b0, 1'b1, 4'h0, "fall1");
`ifndef EDGE_DET_SYNC_EN
    chk("fall_once", {3'b0, b0.fall}, 4'h1);
    chk("any_once", {3'b0, b0.any_edge}, 4'h1);
`endif
    step(1'b0, 1'b1, 4'h0, "low_after");

    for (int i = 0; i < 6; i++) begin
      step((i % 2) == 0, (i % 2) != 0, 4'h0, "toggle");
`ifndef EDGE_DET_SYNC_EN
      chk("toggle_any", {3'b0, b0.any_edge}, 4'h1);
`endif
    end

    step(1'b1, 1'b1, 4'h0, "pre_rst");
    reset_assert("rst_hi");
    hold_reset("rel_hi");
`ifndef EDGE_DET_SYNC_EN
    chk("rel_hi_rise_rv0", {3'b0, b0.rise}, 4'h1);
    chk("rel_hi_any_rv1", {3'b0, b1.any_edge}, 4'h0);
`endif
    reset_assert("rst_mid_pulse");
    chk("mid_pulse_rise", {3'b0, b0.rise}, 4'h0);
    b0.in = 1'b0;
    b1.in = 1'b1;
    hold_reset("rel_lo");
    chk("rel_lo_any", {3'b0, b0.any_edge}, 4'h0);

    step(1'b0, 1'b1, 4'b0000, "w4_zero");
    step(1'b0, 1'b1, 4'b0101, "w4_a");
`ifndef EDGE_DET_SYNC_EN
    chk("w4_rise_a", b2.rise, 4'b0101);
`endif
    step(1'b0, 1'b1, 4'b0110, "w4_b");
`ifndef EDGE_DET_SYNC_EN
    chk("w4_rise_b", b2.rise, 4'b0010);
    chk("w4_fall_b", b2.fall, 4'b0001);
`endif

    for (int i = 0; i < 300; i++) begin
      step(1'($urandom), 1'($urandom), 4'($urandom), "rand");
      if ((i % 75) == 74) begin
        reset_assert("rand_rst");
        hold_reset("rand_rel");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
